// File: rtl/alu_pkg.sv
// Shared opcode encodings and issue-FSM state type for the ALU issue path.
package alu_pkg;

  localparam logic [2:0] OP_NAND = 3'b000;
  localparam logic [2:0] OP_XOR  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_ASR  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_LSL  = 3'b101;
  localparam logic [2:0] OP_NOT  = 3'b110;
  localparam logic [2:0] OP_LT   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } issue_state_t;

endpackage

// File: rtl/alu_issue_unit_if.sv
// Instruction valid/ready channel into the ALU issue unit.
interface alu_issue_unit_if #(
  parameter int WIDTH  = 8,
  parameter int REG_AW = 3
);
  logic              valid;
  logic              ready;
  logic [2:0]        opcode;
  logic [REG_AW-1:0] rd;
  logic [REG_AW-1:0] rs1;
  logic [REG_AW-1:0] rs2;
  logic              imm_en;
  logic [WIDTH-1:0]  imm;

  modport master (output valid, opcode, rd, rs1, rs2, imm_en, imm, input ready);
  modport slave  (input valid, opcode, rd, rs1, rs2, imm_en, imm, output ready);
endinterface

// File: rtl/alu_regfile.sv
// NUM_REGS x WIDTH register file: two operand read ports, one debug read port,
// one synchronous write port; r0 never takes a write and so always reads zero.
module alu_regfile #(
  parameter int WIDTH    = 8,
  parameter int NUM_REGS = 8,
  localparam int REG_AW  = $clog2(NUM_REGS)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [REG_AW-1:0] rs1_addr_i,
  output logic [WIDTH-1:0]  rs1_data_o,
  input  logic [REG_AW-1:0] rs2_addr_i,
  output logic [WIDTH-1:0]  rs2_data_o,
  input  logic [REG_AW-1:0] dbg_addr_i,
  output logic [WIDTH-1:0]  dbg_data_o,
  input  logic              we_i,
  input  logic [REG_AW-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i
);

  logic [WIDTH-1:0] rf_q [NUM_REGS];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
    end else if (we_i && (waddr_i != '0)) begin
      rf_q[waddr_i] <= wdata_i;
    end
  end

  assign rs1_data_o = rf_q[rs1_addr_i];
  assign rs2_data_o = rf_q[rs2_addr_i];
  assign dbg_data_o = rf_q[dbg_addr_i];

endmodule

// File: rtl/alu_register.sv
// Registered ALU: operands and opcode are captured on the clock edge and the
// result appears on result_o one cycle later.
module alu_register
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] first_i,
  input  logic [WIDTH-1:0] second_i,
  input  logic [2:0]       opcode_i,
  output logic [WIDTH-1:0] result_o
);

  logic [WIDTH-1:0] result_d;
  logic [WIDTH-1:0] result_q;

  always_comb begin
    result_d = '0;
    case (opcode_i)
      OP_NAND: result_d = ~(first_i & second_i);
      OP_XOR:  result_d = first_i ^ second_i;
      OP_ADD:  result_d = first_i + second_i;
      OP_ASR:  result_d = $unsigned($signed(first_i) >>> second_i);
      OP_OR:   result_d = first_i | second_i;
      OP_LSL:  result_d = first_i << second_i;
      OP_NOT:  result_d = ~first_i;
      OP_LT:   result_d = {{(WIDTH-1){1'b0}}, ($signed(first_i) < $signed(second_i))};
      default: result_d = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) result_q <= '0;
    else       result_q <= result_d;
  end

  assign result_o = result_q;

endmodule

// File: rtl/alu_issue_unit.sv
// Non-pipelined issue stage: accept one instruction, present operands to the
// registered ALU, then write its result back. IDLE -> EXEC -> WB -> IDLE.
module alu_issue_unit
  import alu_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int NUM_REGS = 8,
  localparam int REG_AW  = $clog2(NUM_REGS)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  alu_issue_unit_if.slave   instr_if,
  output logic [WIDTH-1:0]  alu_first_o,
  output logic [WIDTH-1:0]  alu_second_o,
  output logic [2:0]        alu_opcode_o,
  input  logic [WIDTH-1:0]  alu_result_i,
  output logic              wb_valid_o,
  output logic [REG_AW-1:0] wb_addr_o,
  output logic [WIDTH-1:0]  wb_data_o,
  output logic              busy_o,
  input  logic [REG_AW-1:0] dbg_addr_i,
  output logic [WIDTH-1:0]  dbg_data_o
);

  issue_state_t      state_q;
  logic [WIDTH-1:0]  first_q;
  logic [WIDTH-1:0]  second_q;
  logic [2:0]        opcode_q;
  logic [REG_AW-1:0] rd_q;

  logic [WIDTH-1:0]  rs1_data;
  logic [WIDTH-1:0]  rs2_data;
  logic              accept;
  logic              in_wb;

  assign accept = (state_q == ST_IDLE) && instr_if.valid;
  assign in_wb  = (state_q == ST_WB);

  alu_regfile #(.WIDTH(WIDTH), .NUM_REGS(NUM_REGS)) u_regfile (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .rs1_addr_i (instr_if.rs1),
    .rs1_data_o (rs1_data),
    .rs2_addr_i (instr_if.rs2),
    .rs2_data_o (rs2_data),
    .dbg_addr_i (dbg_addr_i),
    .dbg_data_o (dbg_data_o),
    .we_i       (in_wb),
    .waddr_i    (rd_q),
    .wdata_i    (alu_result_i)
  );

  // Operands are sampled at accept, so rd==rs1/rs2 sees the pre-write value.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      first_q  <= '0;
      second_q <= '0;
      opcode_q <= '0;
      rd_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            first_q  <= rs1_data;
            second_q <= instr_if.imm_en ? instr_if.imm : rs2_data;
            opcode_q <= instr_if.opcode;
            rd_q     <= instr_if.rd;
            state_q  <= ST_EXEC;
          end
        end
        ST_EXEC: state_q <= ST_WB;
        ST_WB:   state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign instr_if.ready = (state_q == ST_IDLE);
  assign busy_o         = (state_q != ST_IDLE);
  assign alu_first_o    = first_q;
  assign alu_second_o   = second_q;
  assign alu_opcode_o   = opcode_q;
  assign wb_valid_o     = in_wb;
  assign wb_addr_o      = in_wb ? rd_q : '0;
  assign wb_data_o      = in_wb ? alu_result_i : '0;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed bench: alu_issue_unit driving a real alu_register, WIDTH=8, NUM_REGS=8.
module tb_alu_issue_unit;
  import alu_pkg::*;

  localparam int WIDTH    = 8;
  localparam int NUM_REGS = 8;
  localparam int REG_AW   = 3;

  logic              clk;
  logic              rst;
  logic [WIDTH-1:0]  alu_first, alu_second, alu_result;
  logic [2:0]        alu_opcode;
  logic              wb_valid;
  logic [REG_AW-1:0] wb_addr;
  logic [WIDTH-1:0]  wb_data;
  logic              busy;
  logic [REG_AW-1:0] dbg_addr;
  logic [WIDTH-1:0]  dbg_data;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] rf_m [NUM_REGS];

  alu_issue_unit_if #(.WIDTH(WIDTH), .REG_AW(REG_AW)) instr_if ();

  alu_issue_unit #(.WIDTH(WIDTH), .NUM_REGS(NUM_REGS)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .instr_if     (instr_if.slave),
    .alu_first_o  (alu_first),
    .alu_second_o (alu_second),
    .alu_opcode_o (alu_opcode),
    .alu_result_i (alu_result),
    .wb_valid_o   (wb_valid),
    .wb_addr_o    (wb_addr),
    .wb_data_o    (wb_data),
    .busy_o       (busy),
    .dbg_addr_i   (dbg_addr),
    .dbg_data_o   (dbg_data)
  );

  alu_register #(.WIDTH(WIDTH)) u_alu (
    .clk_i    (clk),
    .rst_i    (rst),
    .first_i  (alu_first),
    .second_i (alu_second),
    .opcode_i (alu_opcode),
    .result_o (alu_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic dbg_check(input string tag, input logic [REG_AW-1:0] a, input logic [WIDTH-1:0] exp);
    dbg_addr = a;
    #1;
    check(tag, {24'd0, dbg_data}, {24'd0, exp});
  endtask

  // One full instruction from IDLE; expected result is hand-computed by the caller.
  task automatic issue(input string tag, input logic [2:0] op, input logic [REG_AW-1:0] rd,
                       input logic [REG_AW-1:0] rs1, input logic [REG_AW-1:0] rs2,
                       input logic imm_en, input logic [WIDTH-1:0] imm,
                       input logic [WIDTH-1:0] exp_data);
    logic [WIDTH-1:0] exp_first, exp_second;
    exp_first  = rf_m[rs1];
    exp_second = imm_en ? imm : rf_m[rs2];
    check({tag, "_ready_idle"}, {31'd0, instr_if.ready}, 32'd1);
    instr_if.valid  = 1'b1;
    instr_if.opcode = op;
    instr_if.rd     = rd;
    instr_if.rs1    = rs1;
    instr_if.rs2    = rs2;
    instr_if.imm_en = imm_en;
    instr_if.imm    = imm;
    step();
    instr_if.valid = 1'b0;
    check({tag, "_exec_ready"},  {31'd0, instr_if.ready}, 32'd0);
    check({tag, "_exec_busy"},   {31'd0, busy}, 32'd1);
    check({tag, "_exec_wbv"},    {31'd0, wb_valid}, 32'd0);
    check({tag, "_first"},       {24'd0, alu_first}, {24'd0, exp_first});
    check({tag, "_second"},      {24'd0, alu_second}, {24'd0, exp_second});
    check({tag, "_opcode"},      {29'd0, alu_opcode}, {29'd0, op});
    step();
    check({tag, "_wb_valid"},    {31'd0, wb_valid}, 32'd1);
    check({tag, "_wb_addr"},     {29'd0, wb_addr}, {29'd0, rd});
    check({tag, "_wb_data"},     {24'd0, wb_data}, {24'd0, exp_data});
    dbg_check({tag, "_dbg_old"}, rd, rf_m[rd]);
    step();
    if (rd != '0) rf_m[rd] = exp_data;
    check({tag, "_wbv_done"},    {31'd0, wb_valid}, 32'd0);
    dbg_check({tag, "_dbg_new"}, rd, rf_m[rd]);
  endtask

  initial begin
    for (int i = 0; i < NUM_REGS; i++) rf_m[i] = '0;
    rst = 1'b1;
    dbg_addr = '0;
    instr_if.valid  = 1'b0;
    instr_if.opcode = '0;
    instr_if.rd     = '0;
    instr_if.rs1    = '0;
    instr_if.rs2    = '0;
    instr_if.imm_en = 1'b0;
    instr_if.imm    = '0;

    // Reset
    step();
    step();
    rst = 1'b0;
    check("rst_ready",  {31'd0, instr_if.ready}, 32'd1);
    check("rst_busy",   {31'd0, busy}, 32'd0);
    check("rst_wbv",    {31'd0, wb_valid}, 32'd0);
    check("rst_wbaddr", {29'd0, wb_addr}, 32'd0);
    check("rst_wbdata", {24'd0, wb_data}, 32'd0);
    check("rst_first",  {24'd0, alu_first}, 32'd0);
    check("rst_second", {24'd0, alu_second}, 32'd0);
    check("rst_opcode", {29'd0, alu_opcode}, 32'd0);
    for (int i = 0; i < NUM_REGS; i++) dbg_check("rst_rf", REG_AW'(i), 8'h00);

    // Basic ADD chain
    issue("add_r1", OP_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 8'd100, 8'h64);
    issue("add_r2", OP_ADD, 3'd2, 3'd0, 3'd0, 1'b1, 8'd50,  8'h32);
    issue("add_r3", OP_ADD, 3'd3, 3'd1, 3'd2, 1'b0, 8'hFF,  8'h96);
    dbg_check("dbg_r3", 3'd3, 8'h96);

    // rd==rs1 uses the old value; ADD wraps
    issue("self_r3", OP_ADD, 3'd3, 3'd3, 3'd0, 1'b1, 8'h01, 8'h97);
    issue("wrap_r3", OP_ADD, 3'd3, 3'd3, 3'd0, 1'b1, 8'h70, 8'h07);

    // valid held high across two instructions
    instr_if.valid  = 1'b1;
    instr_if.opcode = OP_ADD;
    instr_if.rd     = 3'd5;
    instr_if.rs1    = 3'd0;
    instr_if.imm_en = 1'b1;
    instr_if.imm    = 8'h0A;
    step();
    check("hold_a_ready0", {31'd0, instr_if.ready}, 32'd0);
    instr_if.rd  = 3'd6;
    instr_if.imm = 8'h14;
    step();
    check("hold_a_ready1", {31'd0, instr_if.ready}, 32'd0);
    check("hold_a_wbv",    {31'd0, wb_valid}, 32'd1);
    check("hold_a_addr",   {29'd0, wb_addr}, 32'd5);
    check("hold_a_data",   {24'd0, wb_data}, 32'h0A);
    step();
    check("hold_idle_ready", {31'd0, instr_if.ready}, 32'd1);
    check("hold_idle_wbv",   {31'd0, wb_valid}, 32'd0);
    step();
    check("hold_b_ready0", {31'd0, instr_if.ready}, 32'd0);
    check("hold_b_first",  {24'd0, alu_first}, 32'd0);
    check("hold_b_second", {24'd0, alu_second}, 32'h14);
    instr_if.valid = 1'b0;
    step();
    check("hold_b_ready1", {31'd0, instr_if.ready}, 32'd0);
    check("hold_b_wbv",    {31'd0, wb_valid}, 32'd1);
    check("hold_b_addr",   {29'd0, wb_addr}, 32'd6);
    check("hold_b_data",   {24'd0, wb_data}, 32'h14);
    step();
    check("hold_b_wbv_done", {31'd0, wb_valid}, 32'd0);
    rf_m[5] = 8'h0A;
    rf_m[6] = 8'h14;
    dbg_check("hold_r5", 3'd5, 8'h0A);

    // Logic, shift and compare
    issue("or_r4",   OP_OR,   3'd4, 3'd0, 3'd0, 1'b1, 8'h99, 8'h99);
    issue("asr_r5",  OP_ASR,  3'd5, 3'd4, 3'd0, 1'b1, 8'h02, 8'hE6);
    issue("lt_r6",   OP_LT,   3'd6, 3'd2, 3'd1, 1'b0, 8'h00, 8'h01);
    issue("nand_r7", OP_NAND, 3'd7, 3'd4, 3'd4, 1'b0, 8'h00, 8'h66);

    // Write to r0 is discarded but still strobes
    issue("add_r0", OP_ADD, 3'd0, 3'd0, 3'd0, 1'b1, 8'h05, 8'h05);
    dbg_check("dbg_r0", 3'd0, 8'h00);

    // Reset during EXEC drops the instruction
    instr_if.valid  = 1'b1;
    instr_if.opcode = OP_ADD;
    instr_if.rd     = 3'd1;
    instr_if.rs1    = 3'd0;
    instr_if.imm_en = 1'b1;
    instr_if.imm    = 8'h07;
    step();
    check("mid_exec_busy", {31'd0, busy}, 32'd1);
    instr_if.valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_wbv",   {31'd0, wb_valid}, 32'd0);
    check("mid_rst_ready", {31'd0, instr_if.ready}, 32'd1);
    check("mid_rst_first", {24'd0, alu_first}, 32'd0);
    step();
    check("mid_after_wbv",   {31'd0, wb_valid}, 32'd0);
    check("mid_after_ready", {31'd0, instr_if.ready}, 32'd1);
    dbg_check("mid_r1", 3'd1, 8'h00);
    dbg_check("mid_r4", 3'd4, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
